clkbr_enable_seq: RTL and testbench



---
 rtl/clkbr_enable_seq.sv | 111 +++++++++++
 tb/tb_clkbr_enable_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/clkbr_enable_seq.sv
// Round-robin sequencer for gated clock-branch enables. Changes one branch at a time and holds a
// settle interval between EN and ACK edges to limit load steps on the clock tree.
module clkbr_enable_seq #(
  parameter int unsigned NUM_BR = 4,
  parameter int unsigned SETTLE = 8,
  parameter int unsigned CW     = 8
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic [NUM_BR-1:0] REQ,
  output logic [NUM_BR-1:0] EN,
  output logic [NUM_BR-1:0] ACK,
  output logic              BUSY
);

  localparam int unsigned PW = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;
  localparam logic [PW-1:0] PtrRst  = PW'(NUM_BR - 1);
  localparam logic [CW-1:0] CntLoad = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    StIdle,
    StOnWait,
    StOffWait
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [PW-1:0]      ptr_q;
  logic [NUM_BR-1:0]  en_q;
  logic [NUM_BR-1:0]  ack_q;
  logic               busy_q;

  logic [NUM_BR-1:0]  pend;
  logic [PW-1:0]      pick;
  logic               found;
  int                 idx;

  assign pend = REQ ^ en_q;

  // First pending branch strictly after the last one served, wrapping modulo NUM_BR.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= int'(NUM_BR); k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= int'(NUM_BR)) begin
        idx = idx - int'(NUM_BR);
      end
      if (!found && pend[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= PtrRst;
      en_q    <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            ptr_q  <= pick;
            busy_q <= 1'b1;
            cnt_q  <= CntLoad;
            if (REQ[pick]) begin
              en_q[pick] <= 1'b1;
              state_q    <= StOnWait;
            end else begin
              // ACK drops first so consumers quiesce before the clock stops.
              ack_q[pick] <= 1'b0;
              state_q     <= StOffWait;
            end
          end
        end
        StOnWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            ack_q[ptr_q] <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        StOffWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            en_q[ptr_q] <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign EN   = en_q;
  assign ACK  = ack_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_clkbr_enable_seq.sv
// Bench for clkbr_enable_seq: expected output events are queued by the stimulus and popped by a
// monitor whenever EN/ACK/BUSY change, checking values and edge spacing.
module tb_clkbr_enable_seq;

  logic       clk;
  logic       rn;
  logic [3:0] req;
  logic [3:0] en;
  logic [3:0] ack;
  logic       busy;
  logic [1:0] req_s;
  logic [1:0] en_s;
  logic [1:0] ack_s;
  logic       busy_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;

  typedef struct {
    logic [3:0] en;
    logic [3:0] ack;
    logic       busy;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  logic [8:0] prev = '0;

  clkbr_enable_seq #(.NUM_BR(4), .SETTLE(4), .CW(8)) u_dut (
    .CLK (clk),
    .RN  (rn),
    .REQ (req),
    .EN  (en),
    .ACK (ack),
    .BUSY(busy)
  );

  clkbr_enable_seq #(.NUM_BR(2), .SETTLE(1), .CW(8)) u_small (
    .CLK (clk),
    .RN  (rn),
    .REQ (req_s),
    .EN  (en_s),
    .ACK (ack_s),
    .BUSY(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] e, input logic [3:0] a, input logic b, input int gap);
    exp_t x;
    x.en   = e;
    x.ack  = a;
    x.busy = b;
    x.gap  = gap;
    exp_q.push_back(x);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout actual=%0d pending events required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: any change of the main DUT outputs must match the next queued event.
  always @(negedge clk) begin
    logic [8:0] cur;
    exp_t e;
    cur = {en, ack, busy};
    if (cur !== prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual=%0h required=no change", cur);
      end else begin
        e = exp_q.pop_front();
        check("evt_en", 32'(en), 32'(e.en));
        check("evt_ack", 32'(ack), 32'(e.ack));
        check("evt_busy", 32'(busy), 32'(e.busy));
        if (e.gap != 0) check("evt_gap", 32'(cyc - last_cyc), 32'(e.gap));
      end
      prev     = cur;
      last_cyc = cyc;
    end
    check("inv_main", 32'(ack & ~en), 32'h0);
    check("inv_small", 32'(ack_s & ~en_s), 32'h0);
  end

  initial begin
    rn    = 1'b1;
    req   = 4'b1111;
    req_s = 2'b00;
    #1 rn = 1'b0;
    #2;
    check("rst_en", 32'(en), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_small", 32'({en_s, ack_s, busy_s}), 32'h0);
    repeat (2) @(negedge clk);

    // Power-up with all requests: order 0,1,2,3 at 5-edge spacing.
    push(4'b0001, 4'b0000, 1, 0); push(4'b0001, 4'b0001, 0, 4);
    push(4'b0011, 4'b0001, 1, 1); push(4'b0011, 4'b0011, 0, 4);
    push(4'b0111, 4'b0011, 1, 1); push(4'b0111, 4'b0111, 0, 4);
    push(4'b1111, 4'b0111, 1, 1); push(4'b1111, 4'b1111, 0, 4);
    rn = 1'b1;
    drain("power_up");

    req = 4'b0000;
    push(4'b1111, 4'b1110, 1, 0); push(4'b1110, 4'b1110, 0, 4);
    push(4'b1110, 4'b1100, 1, 1); push(4'b1100, 4'b1100, 0, 4);
    push(4'b1100, 4'b1000, 1, 1); push(4'b1000, 4'b1000, 0, 4);
    push(4'b1000, 4'b0000, 1, 1); push(4'b0000, 4'b0000, 0, 4);
    drain("all_off");

    // Single branch on then off.
    req = 4'b0100;
    push(4'b0100, 4'b0000, 1, 0); push(4'b0100, 4'b0100, 0, 4);
    drain("single_on");
    req = 4'b0000;
    push(4'b0100, 4'b0000, 1, 0); push(4'b0000, 4'b0000, 0, 4);
    drain("single_off");

    // Round-robin after serving branch 1.
    req = 4'b0010;
    push(4'b0010, 4'b0000, 1, 0); push(4'b0010, 4'b0010, 0, 4);
    drain("rr_b1");
    req = 4'b0111;
    push(4'b0110, 4'b0010, 1, 0); push(4'b0110, 4'b0110, 0, 4);
    push(4'b0111, 4'b0110, 1, 1); push(4'b0111, 4'b0111, 0, 4);
    drain("rr_on");
    req = 4'b0000;
    push(4'b0111, 4'b0101, 1, 0); push(4'b0101, 4'b0101, 0, 4);
    push(4'b0101, 4'b0001, 1, 1); push(4'b0001, 4'b0001, 0, 4);
    push(4'b0001, 4'b0000, 1, 1); push(4'b0000, 4'b0000, 0, 4);
    drain("rr_off");

    // Two-cycle request pulse still yields a full on/off pair; EN high 9 edges.
    req = 4'b0001;
    push(4'b0001, 4'b0000, 1, 0); push(4'b0001, 4'b0001, 0, 4);
    push(4'b0001, 4'b0000, 1, 1); push(4'b0000, 4'b0000, 0, 4);
    repeat (2) @(posedge clk);
    @(negedge clk) req = 4'b0000;
    drain("withdraw");

    // Asynchronous reset during ON_WAIT with cnt=2.
    req = 4'b0001;
    push(4'b0001, 4'b0000, 1, 0);
    push(4'b0000, 4'b0000, 0, 0);
    repeat (2) @(posedge clk);
    #2 rn = 1'b0;
    #1;
    check("async_rst_en", 32'(en), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    check("rst_queue", 32'(exp_q.size()), 32'h0);
    push(4'b0001, 4'b0000, 1, 0); push(4'b0001, 4'b0001, 0, 4);
    rn = 1'b1;
    drain("restart");
    req = 4'b0000;
    push(4'b0001, 4'b0000, 1, 0); push(4'b0000, 4'b0000, 0, 4);
    drain("restart_off");

    // SETTLE=1, NUM_BR=2 instance.
    req_s = 2'b11;
    @(posedge clk) #1;
    check("s1_t0", 32'({en_s, ack_s, busy_s}), 32'b01_00_1);
    @(posedge clk) #1;
    check("s1_t1", 32'({en_s, ack_s, busy_s}), 32'b01_01_0);
    @(posedge clk) #1;
    check("s1_t2", 32'({en_s, ack_s, busy_s}), 32'b11_01_1);
    @(posedge clk) #1;
    check("s1_t3", 32'({en_s, ack_s, busy_s}), 32'b11_11_0);
    repeat (3) @(posedge clk) #1;
    check("s1_hold", 32'({en_s, ack_s, busy_s}), 32'b11_11_0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
